// File: rtl/sm_divider_if.sv
// Handshake and operand/result bundle for the sign-magnitude divider.
// The master drives start and the operands; the slave returns status and results.
interface sm_divider_if;
    logic       start;
    logic [4:0] dividend;
    logic [2:0] divisor;
    logic       busy;
    logic       done;
    logic [4:0] quotient;
    logic [2:0] remainder;
    logic       zero_flag;
    logic       div_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, zero_flag, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, zero_flag, div_zero
    );
endinterface

// File: rtl/sm_divider.sv
// Sign-magnitude restoring divider: 4-bit magnitude by 2-bit magnitude,
// one quotient bit per clock, with registered status and result outputs.
module sm_divider (
    input logic         clk,
    input logic         rst,
    sm_divider_if.slave bus
);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t     r_state;
    logic [3:0] r_mag;
    logic       r_dvdSign;
    logic [1:0] r_dsr;
    logic       r_dsrSign;
    logic [2:0] r_partRem;
    logic [1:0] r_count;
    logic       r_busy;
    logic       r_done;
    logic [4:0] r_quot;
    logic [2:0] r_rem;
    logic       r_zero;
    logic       r_divZero;

    logic [2:0] w_trial;
    logic       w_ge;
    logic [2:0] w_remNext;
    logic [3:0] w_magNext;
    logic       w_qSign;
    logic       w_rSign;

    // Partial remainder stays below the divisor, so shifting one bit in fits in 3 bits.
    assign w_trial   = (r_partRem << 1) | {2'b00, r_mag[3]};
    assign w_ge      = (w_trial >= {1'b0, r_dsr});
    assign w_remNext = w_ge ? (w_trial - {1'b0, r_dsr}) : w_trial;
    assign w_magNext = {r_mag[2:0], w_ge};
    assign w_qSign   = (r_dvdSign ^ r_dsrSign) & (|w_magNext);
    assign w_rSign   = r_dvdSign & (|w_remNext[1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_mag     <= 4'd0;
            r_dvdSign <= 1'b0;
            r_dsr     <= 2'd0;
            r_dsrSign <= 1'b0;
            r_partRem <= 3'd0;
            r_count   <= 2'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_quot    <= 5'd0;
            r_rem     <= 3'd0;
            r_zero    <= 1'b0;
            r_divZero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_mag     <= bus.dividend[3:0];
                        r_dvdSign <= bus.dividend[4];
                        r_dsr     <= bus.divisor[1:0];
                        r_dsrSign <= bus.divisor[2];
                        r_partRem <= 3'd0;
                        r_count   <= 2'd3;
                        if (bus.divisor[1:0] == 2'd0) begin
                            r_state   <= DONE;
                            r_done    <= 1'b1;
                            r_quot    <= 5'd0;
                            r_rem     <= 3'd0;
                            r_zero    <= 1'b1;
                            r_divZero <= 1'b1;
                        end else begin
                            r_state <= DIV;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                DIV: begin
                    // Dividend magnitude shifts out MSB-first while quotient bits shift in.
                    r_partRem <= w_remNext;
                    r_mag     <= w_magNext;
                    r_count   <= r_count - 2'd1;
                    if (r_count == 2'd0) begin
                        r_state   <= DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_quot    <= {w_qSign, w_magNext};
                        r_rem     <= {w_rSign, w_remNext[1:0]};
                        r_zero    <= (w_magNext == 4'd0);
                        r_divZero <= 1'b0;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.quotient  = r_quot;
    assign bus.remainder = r_rem;
    assign bus.zero_flag = r_zero;
    assign bus.div_zero  = r_divZero;

endmodule

// File: tb/tb_sm_divider.sv
// Scoreboard bench for sm_divider: directed vector table, start/reset corner
// sequences and an exhaustive sweep against an integer reference model.
module tb_sm_divider;

    typedef struct {
        logic [4:0] q;
        logic [2:0] r;
        logic       z;
        logic       dz;
        int         lat;
    } expT;

    typedef struct {
        logic [4:0] dd;
        logic [2:0] ds;
        logic [4:0] q;
        logic [2:0] r;
        logic       z;
        logic       dz;
    } vecT;

    logic clk;
    logic rst;
    int   nCompared;
    int   nMismatched;
    expT  sbQ[$];
    vecT  vecs[8];

    sm_divider_if bus ();

    sm_divider dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic expT refDiv(input logic [4:0] dd, input logic [2:0] ds);
        expT e;
        int  qm;
        int  rm;
        if (ds[1:0] == 2'd0) begin
            e = '{q: 5'd0, r: 3'd0, z: 1'b1, dz: 1'b1, lat: 0};
        end else begin
            qm    = int'(dd[3:0]) / int'(ds[1:0]);
            rm    = int'(dd[3:0]) % int'(ds[1:0]);
            e.q   = {((dd[4] ^ ds[2]) && qm != 0), 4'(qm)};
            e.r   = {(dd[4] && rm != 0), 2'(rm)};
            e.z   = (qm == 0);
            e.dz  = 1'b0;
            e.lat = 4;
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic launch(input logic [4:0] dd, input logic [2:0] ds, input bit push, input expT e);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = dd;
        bus.divisor  = ds;
        if (push) sbQ.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Called in the cycle after the accepting edge; counts busy cycles until done.
    task automatic waitResult(input bit scramble, output expT got);
        int cycles;
        int busyCnt;
        cycles  = 0;
        busyCnt = 0;
        got     = '{q: 5'd0, r: 3'd0, z: 1'b0, dz: 1'b0, lat: 0};
        while (!bus.done && cycles < 20) begin
            if (bus.busy) busyCnt++;
            if (scramble) begin
                bus.dividend = 5'($urandom);
                bus.divisor  = 3'($urandom);
            end
            @(negedge clk);
            cycles++;
        end
        checkOutput("doneSeen", bus.done, 1);
        checkOutput("sbDepth", sbQ.size(), 1);
        if (bus.done && sbQ.size() > 0) begin
            got = sbQ.pop_front();
            checkOutput("quotient", bus.quotient, got.q);
            checkOutput("remainder", bus.remainder, got.r);
            checkOutput("zero_flag", bus.zero_flag, got.z);
            checkOutput("div_zero", bus.div_zero, got.dz);
            checkOutput("latency", cycles, got.lat);
            checkOutput("busyCycles", busyCnt, got.lat);
            checkOutput("busyWithDone", bus.busy, 0);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] dd, input logic [2:0] ds, input expT e);
        expT got;
        launch(dd, ds, 1'b1, e);
        waitResult(1'b0, got);
        @(negedge clk);
        checkOutput("donePulse", bus.done, 0);
        checkOutput("holdQuot", bus.quotient, got.q);
        checkOutput("holdRem", bus.remainder, got.r);
    endtask

    initial begin
        expT e;
        expT got;
        int  doneCnt;

        clk          = 1'b0;
        rst          = 1'b1;
        nCompared    = 0;
        nMismatched  = 0;
        bus.start    = 1'b0;
        bus.dividend = 5'd0;
        bus.divisor  = 3'd0;

        vecs[0] = '{dd: 5'b01001, ds: 3'b010, q: 5'b00100, r: 3'b001, z: 1'b0, dz: 1'b0};
        vecs[1] = '{dd: 5'b11001, ds: 3'b011, q: 5'b10011, r: 3'b000, z: 1'b0, dz: 1'b0};
        vecs[2] = '{dd: 5'b10111, ds: 3'b110, q: 5'b00011, r: 3'b101, z: 1'b0, dz: 1'b0};
        vecs[3] = '{dd: 5'b00110, ds: 3'b100, q: 5'b00000, r: 3'b000, z: 1'b1, dz: 1'b1};
        vecs[4] = '{dd: 5'b00010, ds: 3'b011, q: 5'b00000, r: 3'b010, z: 1'b1, dz: 1'b0};
        vecs[5] = '{dd: 5'b01111, ds: 3'b001, q: 5'b01111, r: 3'b000, z: 1'b0, dz: 1'b0};
        vecs[6] = '{dd: 5'b10000, ds: 3'b010, q: 5'b00000, r: 3'b000, z: 1'b1, dz: 1'b0};
        vecs[7] = '{dd: 5'b11111, ds: 3'b111, q: 5'b00101, r: 3'b000, z: 1'b0, dz: 1'b0};

        repeat (3) @(negedge clk);
        checkOutput("rstBusy", bus.busy, 0);
        checkOutput("rstDone", bus.done, 0);
        checkOutput("rstQuot", bus.quotient, 0);
        checkOutput("rstRem", bus.remainder, 0);
        checkOutput("rstZero", bus.zero_flag, 0);
        checkOutput("rstDivZero", bus.div_zero, 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            e = '{q: vecs[i].q, r: vecs[i].r, z: vecs[i].z, dz: vecs[i].dz,
                  lat: (vecs[i].dz ? 0 : 4)};
            applyStimulus(vecs[i].dd, vecs[i].ds, e);
        end

        // start held high with operands churning: one result from the latched 9/2,
        // start ignored in DONE, then accepted again in the following IDLE cycle.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 5'b01001;
        bus.divisor  = 3'b010;
        sbQ.push_back('{q: 5'b00100, r: 3'b001, z: 1'b0, dz: 1'b0, lat: 4});
        @(negedge clk);
        waitResult(1'b1, got);
        bus.dividend = 5'b01111;
        bus.divisor  = 3'b001;
        @(negedge clk);
        checkOutput("holdDoneDrop", bus.done, 0);
        checkOutput("holdIgnoredInDone", bus.busy, 0);
        checkOutput("holdQuotKept", bus.quotient, 5'b00100);
        sbQ.push_back('{q: 5'b01111, r: 3'b000, z: 1'b0, dz: 1'b0, lat: 4});
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("holdRestartBusy", bus.busy, 1);
        waitResult(1'b0, got);
        @(negedge clk);

        // Reset two edges into a division aborts it without a done pulse.
        e = '{q: 5'd0, r: 3'd0, z: 1'b0, dz: 1'b0, lat: 0};
        launch(5'b01001, 3'b010, 1'b0, e);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abortBusy", bus.busy, 0);
        checkOutput("abortDone", bus.done, 0);
        checkOutput("abortQuot", bus.quotient, 0);
        checkOutput("abortRem", bus.remainder, 0);
        checkOutput("abortZero", bus.zero_flag, 0);
        checkOutput("abortDivZero", bus.div_zero, 0);
        doneCnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.done) doneCnt++;
        end
        checkOutput("abortNoDone", doneCnt, 0);
        applyStimulus(5'b01001, 3'b010, '{q: 5'b00100, r: 3'b001, z: 1'b0, dz: 1'b0, lat: 4});

        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 8; j++) begin
                applyStimulus(5'(i), 3'(j), refDiv(5'(i), 3'(j)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/sm_divider.md
SM_DIVIDER -- requirements
Module: sm_divider

Interface
REQ-001 The module SHALL have these ports, clock and reset first; clock and reset are decided as stated.
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- dividend  input  5  sign-magnitude: bit4 sign, [3:0] magnitude 0..15.
- divisor  input  3  sign-magnitude: bit2 sign, [1:0] magnitude 0..3.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle completion pulse.
- quotient  output  5  sign-magnitude: bit4 sign, [3:0] magnitude.
- remainder  output  3  sign-magnitude: bit2 sign, [1:0] magnitude.
- zero_flag  output  1  high when the quotient magnitude is 0.
- div_zero  output  1  high when the divisor magnitude was 0.

Function
REQ-002 The module SHALL implement states IDLE, DIV and DONE, with all outputs registered.
REQ-003 IDLE with start=1 at edge k SHALL latch dividend and divisor and clear the partial remainder.
- Divisor magnitude nonzero: enter DIV with iteration count 3.
- Divisor magnitude zero: enter DONE directly.
REQ-004 DIV SHALL perform one restoring-division step per edge, MSB of the dividend magnitude first.
- Shift the next bit into the partial remainder.
- If partial remainder >= divisor magnitude: subtract and set the quotient bit to 1; otherwise set it to 0.
REQ-005 The 4th DIV step SHALL occur at edge k+4; that edge SHALL load quotient, remainder, zero_flag and div_zero and enter DONE.
REQ-006 done SHALL be 1 only during DONE, for exactly one cycle; DONE SHALL return to IDLE on the next edge.
- Normal division: done high in the cycle after edge k+4.
- Divide-by-zero: done high in the cycle after edge k.
REQ-007 busy SHALL be 1 only in DIV; busy and done SHALL never be high together.
REQ-008 start SHALL be ignored in DIV and DONE; operand changes after edge k SHALL NOT affect the result.
REQ-009 Quotient sign SHALL be dividend sign XOR divisor sign, forced to 0 when the quotient magnitude is 0.
REQ-010 Remainder sign SHALL be the dividend sign, forced to 0 when the remainder magnitude is 0.
REQ-011 Remainder magnitude SHALL always be less than the divisor magnitude; the partial remainder SHALL be 3 bits wide so comparisons never overflow.
REQ-012 zero_flag SHALL equal (quotient magnitude == 0) for each completed result, including divide-by-zero.
REQ-013 Divide-by-zero SHALL produce quotient=5'b00000, remainder=3'b000, div_zero=1, zero_flag=1.
REQ-014 div_zero SHALL be 0 for every nonzero-divisor result.
REQ-015 quotient, remainder, zero_flag and div_zero SHALL hold their values until the next completion or reset.
REQ-016 A negative-zero dividend (sign=1, magnitude 0) SHALL give an all-zero quotient and remainder.

Reset
REQ-017 rst=1 at an edge SHALL force IDLE, with busy=0, done=0, quotient=0, remainder=0, zero_flag=0, div_zero=0; this takes priority over start.
REQ-018 rst during DIV or DONE SHALL abort the operation with no done pulse; the next start after rst deasserts SHALL operate normally.

Verification
REQ-019 The bench SHALL cover these directed scenarios.
- dividend=+9 (5'b01001), divisor=+2 (3'b010), start at edge k -> busy for 4 cycles; done after edge k+4; quotient=5'b00100, remainder=3'b001, zero_flag=0, div_zero=0.
- dividend=-9 (5'b11001), divisor=+3 (3'b011) -> quotient=5'b10011, remainder=3'b000 (sign forced 0); dividend=-7 (5'b10111), divisor=-2 (3'b110) -> quotient=5'b00011, remainder=3'b101.
- dividend=+6, divisor=-0 (3'b100) -> done in the cycle after edge k, never busy; div_zero=1, zero_flag=1, quotient=0, remainder=0.
- dividend=+2, divisor=+3 -> quotient=5'b00000, zero_flag=1, remainder=3'b010; dividend=15, divisor=1 -> quotient=5'b01111, remainder=0.
- start held high and operands changed during DIV -> only one done pulse, result from the operands latched at edge k; start in the DONE cycle is ignored, and a start in the next IDLE cycle is accepted.
- rst asserted at edge k+2 mid-division -> all outputs 0, no done pulse; a fresh 9/2 afterwards gives quotient=4, remainder=1.
REQ-020 The bench SHALL exhaustively check all 32x8 operand pairs against a reference model, including sign and zero_flag rules.
